// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the rv32IM instruction fetch unit.
package ifu_fetch_pkg;

  localparam int INSTR_SIZE = 32;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IFU_ST_REQ  = 2'd0,
    IFU_ST_WAIT = 2'd1,
    IFU_ST_DROP = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-side bus bundle: memory request/response plus the decode output stage.
interface ifu_fetch_if
  import ifu_fetch_pkg::*;
#(
  parameter int PC_SIZE = 32
);

  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [PC_SIZE-1:0]    ifu_req_addr;
  logic                  ifu_rsp_valid;
  logic                  ifu_rsp_ready;
  logic [INSTR_SIZE-1:0] ifu_rsp_instr;
  logic                  ifu_rsp_err;
  logic                  ifu_o_valid;
  logic                  ifu_o_ready;
  logic [INSTR_SIZE-1:0] ifu_o_instr;
  logic [PC_SIZE-1:0]    ifu_o_pc;
  logic                  ifu_o_prdt_taken;
  logic                  ifu_o_buserr;

  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
    output ifu_o_valid, ifu_o_instr, ifu_o_pc, ifu_o_prdt_taken, ifu_o_buserr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_rsp_err, ifu_o_ready
  );

  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
    input  ifu_o_valid, ifu_o_instr, ifu_o_pc, ifu_o_prdt_taken, ifu_o_buserr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_rsp_err, ifu_o_ready
  );

endinterface

// File: rtl/ifu_minidec.sv
// Combinational predecoder: spots JAL / conditional branches and extracts
// their sign-extended J/B immediate.
module ifu_minidec
  import ifu_fetch_pkg::*;
#(
  parameter int PC_SIZE = 32
) (
  input  logic [INSTR_SIZE-1:0] instr,
  output logic                  is_jal,
  output logic                  is_bxx,
  output logic [PC_SIZE-1:0]    bjp_imm
);

  logic [20:0] j_imm;
  logic [12:0] b_imm;

  assign j_imm  = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign b_imm  = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  assign is_jal = (instr[6:0] == OPC_JAL);
  assign is_bxx = (instr[6:0] == OPC_BRANCH);

  assign bjp_imm = is_jal ? {{(PC_SIZE-21){j_imm[20]}}, j_imm}
                          : {{(PC_SIZE-13){b_imm[12]}}, b_imm};

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC, single-outstanding fetch FSM, static
// branch prediction and a one-entry output register towards decode.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int                 PC_SIZE  = 32,
  parameter logic [PC_SIZE-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  ifu_fetch_if.master        bus,
  input  logic               flush_valid,
  input  logic [PC_SIZE-1:0] flush_pc
);

  ifu_state_e            state_q, state_d;
  logic [PC_SIZE-1:0]    pc_r, next_pc, bjp_imm;
  logic                  is_jal, is_bxx, prdt_taken;
  logic                  req_valid_q, rsp_ready, rsp_hs, load_rsp;
  logic                  o_valid_q, o_prdt_q, o_buserr_q;
  logic [INSTR_SIZE-1:0] o_instr_q;
  logic [PC_SIZE-1:0]    o_pc_q;

  ifu_minidec #(.PC_SIZE(PC_SIZE)) u_minidec (
    .instr   (bus.ifu_rsp_instr),
    .is_jal  (is_jal),
    .is_bxx  (is_bxx),
    .bjp_imm (bjp_imm)
  );

  // Backward conditional branches and JAL are taken; an erroring fetch never is.
  assign prdt_taken = ~bus.ifu_rsp_err & (is_jal | (is_bxx & bus.ifu_rsp_instr[31]));
  assign next_pc    = prdt_taken ? pc_r + bjp_imm : pc_r + PC_SIZE'(4);

  assign rsp_ready = (state_q == IFU_ST_DROP) |
                     ((state_q == IFU_ST_WAIT) & (~o_valid_q | bus.ifu_o_ready));
  assign rsp_hs    = bus.ifu_rsp_valid & rsp_ready;
  assign load_rsp  = (state_q == IFU_ST_WAIT) & rsp_hs & ~flush_valid;

  // NOTE: state_d takes a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IFU_ST_REQ:
        if (req_valid_q && bus.ifu_req_ready)
          state_d = flush_valid ? IFU_ST_DROP : IFU_ST_WAIT;
      IFU_ST_WAIT:
        if (rsp_hs)           state_d = IFU_ST_REQ;
        else if (flush_valid) state_d = IFU_ST_DROP;
      // The outstanding response retires DROP even under a new flush;
      // waiting for another one would deadlock with one request in flight.
      IFU_ST_DROP:
        if (rsp_hs) state_d = IFU_ST_REQ;
      default: state_d = IFU_ST_REQ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IFU_ST_REQ;
      req_valid_q <= 1'b0;
      pc_r        <= RESET_PC;
    end else begin
      state_q     <= state_d;
      req_valid_q <= (state_d == IFU_ST_REQ);
      if (flush_valid)   pc_r <= flush_pc;
      else if (load_rsp) pc_r <= next_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid_q  <= 1'b0;
      o_instr_q  <= '0;
      o_pc_q     <= '0;
      o_prdt_q   <= 1'b0;
      o_buserr_q <= 1'b0;
    end else if (flush_valid) begin
      o_valid_q  <= 1'b0;
    end else if (load_rsp) begin
      o_valid_q  <= 1'b1;
      o_instr_q  <= bus.ifu_rsp_err ? '0 : bus.ifu_rsp_instr;
      o_pc_q     <= pc_r;
      o_prdt_q   <= prdt_taken;
      o_buserr_q <= bus.ifu_rsp_err;
    end else if (bus.ifu_o_ready) begin
      o_valid_q  <= 1'b0;
    end
  end

  assign bus.ifu_req_valid    = req_valid_q;
  assign bus.ifu_req_addr     = pc_r;
  assign bus.ifu_rsp_ready    = rsp_ready;
  assign bus.ifu_o_valid      = o_valid_q;
  assign bus.ifu_o_instr      = o_instr_q;
  assign bus.ifu_o_pc         = o_pc_q;
  assign bus.ifu_o_prdt_taken = o_prdt_q;
  assign bus.ifu_o_buserr     = o_buserr_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: table of chained fetches plus
// hand-written backpressure and flush sequences, outputs scored from a queue.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_valid;
  logic [31:0] flush_pc;

  always #5 clk = ~clk;

  ifu_fetch_if #(.PC_SIZE(32)) bus ();

  ifu_fetch #(.PC_SIZE(32), .RESET_PC(32'h8000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .flush_valid (flush_valid),
    .flush_pc    (flush_pc)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        prdt;
    logic        buserr;
  } out_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [31:0] pc;
    logic        prdt;
    logic [31:0] nxt;
    logic        do_flush;
  } vec_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  out_t exp_q[$];
  vec_t vecs[13];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All driving happens at negedge+1, request/response sampling at +2,
  // the output monitor at +3: well clear of the rising edge.
  task automatic wait_req(input logic [31:0] addr, input string name);
    int n = 0;
    while (bus.ifu_req_valid !== 1'b1 && n < 64) begin
      @(negedge clk); #1; n++;
    end
    check({name, " req_valid"}, 128'(bus.ifu_req_valid), 128'(1));
    check({name, " req_addr"}, 128'(bus.ifu_req_addr), 128'(addr));
  endtask

  task automatic accept_req();
    bus.ifu_req_ready = 1'b1;
    @(negedge clk); #1;
    bus.ifu_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] instr, input logic err, input logic [31:0] pc,
                         input logic prdt, input bit keep, input string name);
    int   n = 0;
    out_t e;
    bus.ifu_rsp_valid = 1'b1;
    bus.ifu_rsp_instr = instr;
    bus.ifu_rsp_err   = err;
    #1;
    while (bus.ifu_rsp_ready !== 1'b1 && n < 64) begin
      @(negedge clk); #2; n++;
    end
    check({name, " rsp_ready"}, 128'(bus.ifu_rsp_ready), 128'(1));
    if (keep && bus.ifu_rsp_ready === 1'b1) begin
      e.pc     = pc;
      e.instr  = err ? 32'h0 : instr;
      e.prdt   = prdt;
      e.buserr = err;
      exp_q.push_back(e);
    end
    @(negedge clk); #1;
    bus.ifu_rsp_valid = 1'b0;
  endtask

  task automatic flush_now(input logic [31:0] pc);
    flush_valid = 1'b1;
    flush_pc    = pc;
    @(negedge clk); #1;
    flush_valid = 1'b0;
  endtask

  always begin
    out_t e;
    @(negedge clk); #3;
    if (rst_n === 1'b1 && bus.ifu_o_valid === 1'b1 && bus.ifu_o_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("o_valid with empty scoreboard", 128'(bus.ifu_o_valid), 128'(0));
      end else begin
        e = exp_q.pop_front();
        check("output {pc,instr,prdt,buserr}",
              128'({bus.ifu_o_pc, bus.ifu_o_instr, bus.ifu_o_prdt_taken, bus.ifu_o_buserr}),
              128'(e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{NOP,          1'b0, 32'h8000_0000, 1'b0, 32'h8000_0004, 1'b0};
    vecs[1]  = '{NOP,          1'b0, 32'h8000_0004, 1'b0, 32'h8000_0008, 1'b0};
    vecs[2]  = '{NOP,          1'b0, 32'h8000_0008, 1'b0, 32'h8000_000C, 1'b0};
    vecs[3]  = '{32'h1000006F, 1'b1, 32'h8000_000C, 1'b0, 32'h8000_0010, 1'b0};
    vecs[4]  = '{32'hFE000CE3, 1'b0, 32'h8000_0010, 1'b1, 32'h8000_0008, 1'b0};
    vecs[5]  = '{32'h1000006F, 1'b0, 32'h8000_0008, 1'b1, 32'h8000_0108, 1'b0};
    vecs[6]  = '{32'h1000006F, 1'b0, 32'h8000_0000, 1'b1, 32'h8000_0100, 1'b1};
    vecs[7]  = '{32'h00008067, 1'b0, 32'h8000_0100, 1'b0, 32'h8000_0104, 1'b0};
    vecs[8]  = '{32'h00001463, 1'b0, 32'h8000_0010, 1'b0, 32'h8000_0014, 1'b1};
    vecs[9]  = '{32'h80005063, 1'b0, 32'h8000_0014, 1'b1, 32'h7FFF_F014, 1'b0};
    vecs[10] = '{NOP,          1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 1'b1};
    vecs[11] = '{32'hFFDFF06F, 1'b0, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 1'b0};
    vecs[12] = '{NOP,          1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 1'b0};

    rst_n             = 1'b0;
    flush_valid       = 1'b0;
    flush_pc          = '0;
    bus.ifu_req_ready = 1'b0;
    bus.ifu_rsp_valid = 1'b0;
    bus.ifu_rsp_instr = '0;
    bus.ifu_rsp_err   = 1'b0;
    bus.ifu_o_ready   = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check("reset req_valid", 128'(bus.ifu_req_valid), 128'(0));
    check("reset rsp_ready", 128'(bus.ifu_rsp_ready), 128'(0));
    check("reset o_valid", 128'(bus.ifu_o_valid), 128'(0));
    check("reset o_regs",
          128'({bus.ifu_o_pc, bus.ifu_o_instr, bus.ifu_o_prdt_taken, bus.ifu_o_buserr}), 128'(0));
    rst_n = 1'b1;
    @(negedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].do_flush) flush_now(vecs[i].pc);
      wait_req(vecs[i].pc, $sformatf("vec%0d", i));
      accept_req();
      respond(vecs[i].instr, vecs[i].err, vecs[i].pc, vecs[i].prdt, 1'b1, $sformatf("vec%0d", i));
      wait_req(vecs[i].nxt, $sformatf("vec%0d next", i));
    end

    // Decode stalls: the held instruction stays put and the second response waits.
    flush_now(32'h8000_0400);
    bus.ifu_o_ready = 1'b0;
    wait_req(32'h8000_0400, "bp0");
    accept_req();
    respond(NOP, 1'b0, 32'h8000_0400, 1'b0, 1'b1, "bp0");
    wait_req(32'h8000_0404, "bp1");
    accept_req();
    bus.ifu_rsp_valid = 1'b1;
    bus.ifu_rsp_instr = 32'h0010_0093;
    bus.ifu_rsp_err   = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp stall rsp_ready", 128'(bus.ifu_rsp_ready), 128'(0));
      check("bp stall hold {valid,instr,pc}",
            128'({bus.ifu_o_valid, bus.ifu_o_instr, bus.ifu_o_pc}),
            128'({1'b1, NOP, 32'h8000_0400}));
      @(negedge clk); #1;
    end
    bus.ifu_o_ready = 1'b1;
    respond(32'h0010_0093, 1'b0, 32'h8000_0404, 1'b0, 1'b1, "bp1");
    wait_req(32'h8000_0408, "bp2");

    // Flush while waiting; the response turns up three cycles later and is dropped.
    accept_req();
    flush_now(32'h8000_0200);
    for (int k = 0; k < 2; k++) begin
      #1;
      check("drop req_valid", 128'(bus.ifu_req_valid), 128'(0));
      check("drop o_valid", 128'(bus.ifu_o_valid), 128'(0));
      @(negedge clk); #1;
    end
    respond(32'h1000006F, 1'b0, 32'h0, 1'b0, 1'b0, "drop rsp");
    check("after drop req {valid,addr}",
          128'({bus.ifu_req_valid, bus.ifu_req_addr}), 128'({1'b1, 32'h8000_0200}));
    check("after drop o_valid", 128'(bus.ifu_o_valid), 128'(0));
    accept_req();
    respond(NOP, 1'b0, 32'h8000_0200, 1'b0, 1'b1, "flushed fetch");
    wait_req(32'h8000_0204, "flushed next");

    // Flush in the same cycle as the response handshake: straight back to REQ.
    accept_req();
    bus.ifu_rsp_valid = 1'b1;
    bus.ifu_rsp_instr = NOP;
    bus.ifu_rsp_err   = 1'b0;
    flush_valid       = 1'b1;
    flush_pc          = 32'h8000_0600;
    #1;
    check("wait+flush rsp_ready", 128'(bus.ifu_rsp_ready), 128'(1));
    @(negedge clk); #1;
    bus.ifu_rsp_valid = 1'b0;
    flush_valid       = 1'b0;
    check("wait+flush req {valid,addr}",
          128'({bus.ifu_req_valid, bus.ifu_req_addr}), 128'({1'b1, 32'h8000_0600}));
    check("wait+flush o_valid", 128'(bus.ifu_o_valid), 128'(0));
    accept_req();
    respond(NOP, 1'b0, 32'h8000_0600, 1'b0, 1'b1, "wait+flush fetch");
    wait_req(32'h8000_0604, "wait+flush next");

    // Flush coincides with a request handshake: the in-flight fetch is dropped.
    bus.ifu_req_ready = 1'b1;
    flush_valid       = 1'b1;
    flush_pc          = 32'h8000_0700;
    @(negedge clk); #1;
    bus.ifu_req_ready = 1'b0;
    flush_valid       = 1'b0;
    check("req+flush req_valid", 128'(bus.ifu_req_valid), 128'(0));
    respond(NOP, 1'b0, 32'h0, 1'b0, 1'b0, "req+flush drop");
    check("req+flush req {valid,addr}",
          128'({bus.ifu_req_valid, bus.ifu_req_addr}), 128'({1'b1, 32'h8000_0700}));
    accept_req();
    respond(32'hFE000CE3, 1'b0, 32'h8000_0700, 1'b1, 1'b1, "req+flush fetch");
    wait_req(32'h8000_06F8, "req+flush next");

    repeat (4) @(negedge clk);
    check("scoreboard drained", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
